// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults and 80x60 text-cell geometry for the character scan.
package vga_timing_pkg;

    localparam int H_VIS  = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;
    localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int V_VIS  = 480;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int COLS    = 80;
    localparam int ROWS    = 60;
    localparam int CELL    = 8;
    localparam int CELL_SH = $clog2(CELL);
    localparam int ADDR_W  = $clog2((COLS > ROWS) ? COLS : ROWS);

    localparam logic [ADDR_W-1:0] BLANK_ADDR = 7'd127;

    // Signals that must stay aligned with the ROM/font output pixel.
    typedef struct packed {
        logic                 hsync;
        logic                 vsync;
        logic                 video_on;
        logic [CELL_SH-1:0]   glyph_x;
    } scan_tap_t;

    localparam scan_tap_t TAP_RESET = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0, glyph_x: '0};

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register; DEPTH=0 degenerates to a wire.
module vga_delay_line #(
    parameter int               WIDTH     = 6,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];
            logic [WIDTH-1:0] stage_d [DEPTH];

            always_comb begin
                stage_d[0] = din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RESET_VAL;
                    end
                end else if (en) begin
                    stage_q <= stage_d;
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_char_scan.sv
// Raster scan for the 80x60 text display: counters, character address, glyph coordinates,
// and sync/blank delayed to line up with the ROM/font pixel path.
module vga_char_scan #(
    parameter int H_VIS      = vga_timing_pkg::H_VIS,
    parameter int H_FP       = vga_timing_pkg::H_FP,
    parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int H_BP       = vga_timing_pkg::H_BP,
    parameter int V_VIS      = vga_timing_pkg::V_VIS,
    parameter int V_FP       = vga_timing_pkg::V_FP,
    parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int V_BP       = vga_timing_pkg::V_BP,
    parameter int PIPE_DELAY = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               pix_en,
    output logic [vga_timing_pkg::ADDR_W-1:0]  row,
    output logic [vga_timing_pkg::ADDR_W-1:0]  column,
    output logic [vga_timing_pkg::CELL_SH-1:0] glyph_y,
    output logic [vga_timing_pkg::CELL_SH-1:0] glyph_x,
    output logic                               video_on,
    output logic                               hsync_d,
    output logic                               vsync_d,
    output logic                               video_on_d,
    output logic [vga_timing_pkg::CELL_SH-1:0] glyph_x_d,
    output logic                               frame_start
);

    import vga_timing_pkg::*;

    localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);

    localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
    localparam logic [HW-1:0] H_VIS_C = HW'(H_VIS);
    localparam logic [HW-1:0] HS_BEG = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
    localparam logic [VW-1:0] V_VIS_C = VW'(V_VIS);
    localparam logic [VW-1:0] VS_BEG = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_VIS + V_FP + V_SYNC);

    logic [HW-1:0]      hcount_q, hcount_d;
    logic [VW-1:0]      vcount_q, vcount_d;
    logic               started_q, started_d;
    logic [ADDR_W-1:0]  row_q, row_d, column_q, column_d;
    logic [CELL_SH-1:0] gx_q, gx_d, gy_q, gy_d;
    logic               vid_q, vid_d, hs_q, hs_d, vs_q, vs_d;
    logic               frame_start_q, frame_start_d;

    // Outputs are decoded from the next counter values so they land on the same edge as the counters.
    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        started_d     = started_q;
        row_d         = row_q;
        column_d      = column_q;
        gx_d          = gx_q;
        gy_d          = gy_q;
        vid_d         = vid_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        frame_start_d = 1'b0;

        if (pix_en) begin
            started_d = 1'b1;
            if (!started_q) begin
                hcount_d = '0;
                vcount_d = '0;
            end else if (hcount_q == H_LAST) begin
                hcount_d = '0;
                if (vcount_q == V_LAST) begin
                    vcount_d      = '0;
                    frame_start_d = 1'b1;
                end else begin
                    vcount_d = vcount_q + VW'(1);
                end
            end else begin
                hcount_d = hcount_q + HW'(1);
            end

            vid_d    = (hcount_d < H_VIS_C) && (vcount_d < V_VIS_C);
            column_d = vid_d ? ADDR_W'(hcount_d >> CELL_SH) : BLANK_ADDR;
            row_d    = vid_d ? ADDR_W'(vcount_d >> CELL_SH) : BLANK_ADDR;
            gx_d     = hcount_d[CELL_SH-1:0];
            gy_d     = vcount_d[CELL_SH-1:0];
            hs_d     = !((hcount_d >= HS_BEG) && (hcount_d < HS_END));
            vs_d     = !((vcount_d >= VS_BEG) && (vcount_d < VS_END));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            started_q     <= 1'b0;
            row_q         <= BLANK_ADDR;
            column_q      <= BLANK_ADDR;
            gx_q          <= '0;
            gy_q          <= '0;
            vid_q         <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            started_q     <= started_d;
            row_q         <= row_d;
            column_q      <= column_d;
            gx_q          <= gx_d;
            gy_q          <= gy_d;
            vid_q         <= vid_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            frame_start_q <= frame_start_d;
        end
    end

    scan_tap_t tap_now, tap_dly;

    assign tap_now = {hs_q, vs_q, vid_q, gx_q};

    vga_delay_line #(
        .WIDTH     ($bits(scan_tap_t)),
        .DEPTH     (PIPE_DELAY),
        .RESET_VAL (TAP_RESET)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_en),
        .din   (tap_now),
        .dout  (tap_dly)
    );

    assign row         = row_q;
    assign column      = column_q;
    assign glyph_x     = gx_q;
    assign glyph_y     = gy_q;
    assign video_on    = vid_q;
    assign frame_start = frame_start_q;
    assign hsync_d     = tap_dly.hsync;
    assign vsync_d     = tap_dly.vsync;
    assign video_on_d  = tap_dly.video_on;
    assign glyph_x_d   = tap_dly.glyph_x;

endmodule

// File: tb/tb_vga_char_scan.sv
// Bench for vga_char_scan: a full-size instance for first-pixel, line and deep-pixel checks,
// and a shrunken-timing instance for whole-frame, vsync, stall and mid-frame reset checks.
module tb_vga_char_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_a, pix_en_a, rst_n_b, pix_en_b;
    logic [6:0] row_a, column_a, row_b, column_b;
    logic [2:0] glyph_y_a, glyph_x_a, glyph_x_d_a, glyph_y_b, glyph_x_b, glyph_x_d_b;
    logic       video_on_a, hsync_d_a, vsync_d_a, video_on_d_a, frame_start_a;
    logic       video_on_b, hsync_d_b, vsync_d_b, video_on_d_b, frame_start_b;

    int n_checks = 0;
    int n_errors = 0;

    vga_char_scan u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n_a),
        .pix_en      (pix_en_a),
        .row         (row_a),
        .column      (column_a),
        .glyph_y     (glyph_y_a),
        .glyph_x     (glyph_x_a),
        .video_on    (video_on_a),
        .hsync_d     (hsync_d_a),
        .vsync_d     (vsync_d_a),
        .video_on_d  (video_on_d_a),
        .glyph_x_d   (glyph_x_d_a),
        .frame_start (frame_start_a)
    );

    // Small raster: 24 clocks per line (sync 18..20), 22 lines (vsync 18..19), one tick of delay.
    vga_char_scan #(
        .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(16), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .PIPE_DELAY(1)
    ) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n_b),
        .pix_en      (pix_en_b),
        .row         (row_b),
        .column      (column_b),
        .glyph_y     (glyph_y_b),
        .glyph_x     (glyph_x_b),
        .video_on    (video_on_b),
        .hsync_d     (hsync_d_b),
        .vsync_d     (vsync_d_b),
        .video_on_d  (video_on_d_b),
        .glyph_x_d   (glyph_x_d_b),
        .frame_start (frame_start_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Number of mismatching fields of the small instance after tick n (n=0 is the first tick).
    function automatic int mism_b(input int n);
        int h, v, hp, vp, bad;
        logic vis, e_hs, e_vs, e_vid;
        logic [2:0] e_gx;
        h   = n % 24;
        v   = (n / 24) % 22;
        vis = (h < 16) && (v < 16);
        bad = 0;
        if (column_b !== (vis ? 7'(h / 8) : 7'd127)) bad++;
        if (row_b !== (vis ? 7'(v / 8) : 7'd127)) bad++;
        if (glyph_x_b !== 3'(h % 8)) bad++;
        if (glyph_y_b !== 3'(v % 8)) bad++;
        if (video_on_b !== vis) bad++;
        if (n == 0) begin
            e_hs = 1'b1; e_vs = 1'b1; e_vid = 1'b0; e_gx = 3'd0;
        end else begin
            hp    = (n - 1) % 24;
            vp    = ((n - 1) / 24) % 22;
            e_hs  = !((hp >= 18) && (hp < 21));
            e_vs  = !((vp >= 18) && (vp < 20));
            e_vid = (hp < 16) && (vp < 16);
            e_gx  = 3'(hp % 8);
        end
        if (hsync_d_b !== e_hs) bad++;
        if (vsync_d_b !== e_vs) bad++;
        if (video_on_d_b !== e_vid) bad++;
        if (glyph_x_d_b !== e_gx) bad++;
        return bad;
    endfunction

    task automatic pulse_a();
        @(negedge clk) pix_en_a = 1'b1;
        @(negedge clk) pix_en_a = 1'b0;
    endtask

    task automatic pulse_b();
        @(negedge clk) pix_en_b = 1'b1;
        @(negedge clk) pix_en_b = 1'b0;
    endtask

    initial begin
        int bad, lows, first, fs_cnt, fs_at, h, v;
        logic vis;

        rst_n_a = 1'b0; rst_n_b = 1'b0; pix_en_a = 1'b0; pix_en_b = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_row", row_a, 7'd127);
        chk("rst_column", column_a, 7'd127);
        chk("rst_video_on", video_on_a, 1'b0);
        chk("rst_glyph", {glyph_x_a, glyph_y_a, glyph_x_d_a}, 9'd0);
        chk("rst_syncs_d", {hsync_d_a, vsync_d_a}, 2'b11);
        chk("rst_video_on_d", video_on_d_a, 1'b0);
        chk("rst_frame_start", frame_start_a, 1'b0);

        // First pixel after reset shows (0,0) without advancing.
        @(negedge clk) rst_n_a = 1'b1;
        pulse_a();
        chk("first_row", row_a, 7'd0);
        chk("first_column", column_a, 7'd0);
        chk("first_video_on", video_on_a, 1'b1);
        chk("first_glyph_x", glyph_x_a, 3'd0);
        chk("first_video_on_d", video_on_d_a, 1'b0);
        pulse_a();
        chk("tick1_glyph_x", glyph_x_a, 3'd1);
        chk("tick1_video_on_d", video_on_d_a, 1'b0);
        pulse_a();
        chk("tick2_video_on_d", video_on_d_a, 1'b1);

        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (glyph_x_a !== 3'd2 || column_a !== 7'd0 || video_on_d_a !== 1'b1) bad++;
        end
        chk("a_stall_hold", bad, 0);

        // Held-high scan across the first line; hsync_d lags hcount by two ticks.
        pix_en_a = 1'b1;
        bad = 0; lows = 0; first = -1;
        for (int t = 3; t <= 801; t++) begin
            @(negedge clk);
            h = t % 800; v = t / 800;
            vis = (h < 640) && (v < 480);
            if (column_a !== (vis ? 7'(h / 8) : 7'd127)) bad++;
            if (glyph_x_a !== 3'(h % 8) || video_on_a !== vis) bad++;
            if (!hsync_d_a) begin
                lows++;
                if (first < 0) first = t;
            end
        end
        chk("line_column_scan", bad, 0);
        chk("hsync_low_ticks", lows, 96);
        chk("hsync_first_low_tick", first, 658);

        // Pixel (333,77) is tick 77*800+333 = 61933.
        repeat (61933 - 801) @(negedge clk);
        pix_en_a = 1'b0;
        chk("px_column", column_a, 7'd41);
        chk("px_row", row_a, 7'd9);
        chk("px_glyph_x", glyph_x_a, 3'd5);
        chk("px_glyph_y", glyph_y_a, 3'd5);
        chk("px_video_on", video_on_a, 1'b1);
        chk("px_glyph_x_d", glyph_x_d_a, 3'd3);

        // Small instance: one frame with pix_en toggling every other clock.
        @(negedge clk) rst_n_b = 1'b1;
        pulse_b();
        chk("b_first", mism_b(0), 0);
        bad = 0; lows = 0; first = -1; fs_cnt = 0; fs_at = -1;
        for (int t = 1; t <= 528; t++) begin
            @(negedge clk) pix_en_b = 1'b1;
            @(negedge clk) pix_en_b = 1'b0;
            bad += mism_b(t);
            if (frame_start_b) begin
                fs_cnt++;
                fs_at = t;
            end
            if (!vsync_d_b) begin
                lows++;
                if (first < 0) first = t;
            end
            @(negedge clk);
            bad += mism_b(t);
            if (frame_start_b) fs_cnt++;
        end
        chk("b_toggle_frame_model", bad, 0);
        chk("b_frame_start_count", fs_cnt, 1);
        chk("b_frame_start_tick", fs_at, 528);
        chk("b_vsync_low_ticks", lows, 48);
        chk("b_vsync_first_low", first, 433);

        // Second frame with pix_en held high.
        pix_en_b = 1'b1;
        bad = 0; fs_cnt = 0; fs_at = -1;
        for (int t = 529; t <= 1056; t++) begin
            @(negedge clk);
            bad += mism_b(t);
            if (frame_start_b) begin
                fs_cnt++;
                fs_at = t;
            end
        end
        pix_en_b = 1'b0;
        chk("b_held_frame_model", bad, 0);
        chk("b_held_frame_start_count", fs_cnt, 1);
        chk("b_held_frame_start_tick", fs_at, 1056);
        @(negedge clk);
        chk("b_frame_start_clears", frame_start_b, 1'b0);

        bad = 0;
        repeat (10) begin
            @(negedge clk);
            bad += mism_b(1056);
        end
        chk("b_stall_hold", bad, 0);

        // Advance into vsync (line 19, pixel 5) and reset between clock edges.
        pix_en_b = 1'b1;
        bad = 0;
        for (int t = 1057; t <= 1517; t++) begin
            @(negedge clk);
            bad += mism_b(t);
        end
        pix_en_b = 1'b0;
        chk("b_pre_reset_model", bad, 0);
        chk("b_pre_reset_vsync_d", vsync_d_b, 1'b0);
        #2 rst_n_b = 1'b0;
        #1;
        chk("b_async_vsync_d", vsync_d_b, 1'b1);
        chk("b_async_video_on_d", video_on_d_b, 1'b0);
        chk("b_async_glyph", {glyph_x_b, glyph_y_b}, 6'd0);
        chk("b_async_addr", {row_b, column_b}, 14'h3fff);
        repeat (2) @(negedge clk);
        chk("b_reset_hold_syncs", {hsync_d_b, vsync_d_b}, 2'b11);

        // Restart yields a normal frame.
        rst_n_b = 1'b1;
        pulse_b();
        chk("b_restart_first", mism_b(0), 0);
        pix_en_b = 1'b1;
        bad = 0; fs_cnt = 0;
        for (int t = 1; t <= 528; t++) begin
            @(negedge clk);
            bad += mism_b(t);
            if (frame_start_b) fs_cnt++;
        end
        pix_en_b = 1'b0;
        chk("b_restart_frame_model", bad, 0);
        chk("b_restart_frame_start_count", fs_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
